// File: rtl/pkt_fifo_pkg.sv
// Shared constants and helpers for the packet FIFO: default parameters and
// the pointer width (address bits plus one wrap bit).
package pkt_fifo_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_AF_MARGIN = 2;

  // Pointer width for a given depth: log2(depth) address bits plus a wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : pkt_fifo_pkg

// File: rtl/fifo_ram.sv
// DEPTH x DATA_W register array with one synchronous write port and one
// asynchronous (combinational) read port.
module fifo_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: storage is deliberately not reset; validity is tracked by the
  // pointers, and leaving the array resetless lets it map onto plain flops/RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule : fifo_ram

// File: rtl/pkt_fifo.sv
// Packet FIFO: words are written speculatively and become visible to the
// reader only on commit; a discard rolls the write pointer back.
module pkt_fifo
  import pkt_fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,   // power of two, >= 4
  parameter int AF_MARGIN = DEF_AF_MARGIN
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     w_enable,
  input  logic [DATA_W-1:0]        w_data,
  input  logic                     w_commit,
  input  logic                     w_discard,
  input  logic                     r_enable,
  output logic [DATA_W-1:0]        r_data,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  typedef logic [PW-1:0] ptr_t;

  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
  localparam ptr_t AF_P    = ptr_t'(AF_MARGIN);

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t cm_ptr_q, cm_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  ptr_t occupancy;
  ptr_t free_slots;
  logic wr_accept;
  logic rd_accept;
  logic [DATA_W-1:0] ram_rdata;

  // Occupancy counts pending words so a speculative packet cannot be
  // overwritten; the read side looks only at the committed pointer.
  assign count       = cm_ptr_q - rd_ptr_q;
  assign pending     = wr_ptr_q - cm_ptr_q;
  assign occupancy   = wr_ptr_q - rd_ptr_q;
  assign free_slots  = DEPTH_P - occupancy;
  assign empty       = (count == '0);
  assign full        = (occupancy == DEPTH_P);
  assign almost_full = (free_slots <= AF_P);
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

  assign wr_accept = w_enable & ~full & ~w_discard;
  assign rd_accept = r_enable & ~empty;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    cm_ptr_d    = cm_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;

    if (w_discard) begin
      wr_ptr_d = cm_ptr_q;
    end else begin
      if (wr_accept) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (w_commit)  cm_ptr_d = wr_ptr_d;
      overflow_d = w_enable & full;
    end

    if (rd_accept) rd_ptr_d = rd_ptr_q + ptr_t'(1);
    underflow_d = r_enable & empty;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs, independent of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q    <= '0;
      cm_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      cm_ptr_q    <= cm_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_accept),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (w_data),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (ram_rdata)
  );

  assign r_data = empty ? '0 : ram_rdata;

endmodule : pkt_fifo

// File: tb/tb_pkt_fifo.sv
// Directed self-checking bench for pkt_fifo at DATA_W=8, DEPTH=8, AF_MARGIN=2.
module tb_pkt_fifo;

  localparam int DATA_W    = 8;
  localparam int DEPTH     = 8;
  localparam int AF_MARGIN = 2;
  localparam int CW        = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              w_enable;
  logic [DATA_W-1:0] w_data;
  logic              w_commit;
  logic              w_discard;
  logic              r_enable;
  logic [DATA_W-1:0] r_data;
  logic              empty;
  logic              full;
  logic              almost_full;
  logic [CW-1:0]     count;
  logic [CW-1:0]     pending;
  logic              overflow;
  logic              underflow;

  int n_asserts = 0;
  int n_fail    = 0;

  pkt_fifo #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .AF_MARGIN (AF_MARGIN)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .w_enable    (w_enable),
    .w_data      (w_data),
    .w_commit    (w_commit),
    .w_discard   (w_discard),
    .r_enable    (r_enable),
    .r_data      (r_data),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .count       (count),
    .pending     (pending),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  task automatic idle();
    w_enable  = 1'b0;
    w_data    = '0;
    w_commit  = 1'b0;
    w_discard = 1'b0;
    r_enable  = 1'b0;
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_write(input logic [DATA_W-1:0] d, input logic commit);
    w_enable = 1'b1;
    w_data   = d;
    w_commit = commit;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    n_rst = 1'b0;
    #2;
    n_asserts++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %0b want 1", empty); end
    n_asserts++; if (full !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %0b want 0", full); end
    n_asserts++; if (count !== 4'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", count); end
    n_asserts++; if (pending !== 4'd0) begin n_fail++; $display("FAIL rst_pending: got %0d want 0", pending); end
    n_asserts++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL rst_af: got %0b want 0", almost_full); end
    n_asserts++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL rst_flags: got ovf=%0b udf=%0b want 0 0", overflow, underflow); end
    n_asserts++; if (r_data !== 8'h00) begin n_fail++; $display("FAIL rst_rdata: got %h want 00", r_data); end
    tick();
    n_rst = 1'b1;
    tick();
  endtask

  task automatic test_commit_read();
    logic [DATA_W-1:0] exp_words [3];
    exp_words = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++) begin
      drive_write(exp_words[i], 1'b0);
      n_asserts++; if (empty !== 1'b1) begin n_fail++; $display("FAIL cr_empty_pre%0d: got %0b want 1", i, empty); end
    end
    n_asserts++; if (pending !== 4'd3) begin n_fail++; $display("FAIL cr_pending: got %0d want 3", pending); end
    w_commit = 1'b1;
    tick();
    idle();
    n_asserts++; if (count !== 4'd3) begin n_fail++; $display("FAIL cr_count: got %0d want 3", count); end
    n_asserts++; if (empty !== 1'b0) begin n_fail++; $display("FAIL cr_empty_post: got %0b want 0", empty); end
    for (int i = 0; i < 3; i++) begin
      n_asserts++; if (r_data !== exp_words[i]) begin n_fail++; $display("FAIL cr_pop%0d: got %h want %h", i, r_data, exp_words[i]); end
      r_enable = 1'b1;
      tick();
      idle();
    end
    n_asserts++; if (empty !== 1'b1 || r_data !== 8'h00) begin n_fail++; $display("FAIL cr_drained: got empty=%0b data=%h want 1 00", empty, r_data); end
  endtask

  task automatic test_discard();
    drive_write(8'hA1, 1'b0);
    drive_write(8'hA2, 1'b0);
    n_asserts++; if (pending !== 4'd2) begin n_fail++; $display("FAIL dc_pending_pre: got %0d want 2", pending); end
    w_discard = 1'b1;
    w_enable  = 1'b1;
    w_data    = 8'hEE;
    w_commit  = 1'b1;
    tick();
    idle();
    n_asserts++; if (pending !== 4'd0 || count !== 4'd0) begin n_fail++; $display("FAIL dc_dropped: got pending=%0d count=%0d want 0 0", pending, count); end
    drive_write(8'hB1, 1'b1);
    n_asserts++; if (count !== 4'd1) begin n_fail++; $display("FAIL dc_count: got %0d want 1", count); end
    n_asserts++; if (pending !== 4'd0) begin n_fail++; $display("FAIL dc_pending: got %0d want 0", pending); end
    n_asserts++; if (r_data !== 8'hB1) begin n_fail++; $display("FAIL dc_rdata: got %h want b1", r_data); end
    r_enable = 1'b1;
    tick();
    idle();
    n_asserts++; if (empty !== 1'b1) begin n_fail++; $display("FAIL dc_drained: got %0b want 1", empty); end
  endtask

  task automatic test_full_overflow();
    for (int i = 0; i < DEPTH; i++) begin
      drive_write(8'h40 + 8'(i), (i == DEPTH - 1));
      if (i == 4) begin
        n_asserts++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL fo_af5: got %0b want 0", almost_full); end
      end
      if (i == 5) begin
        n_asserts++; if (almost_full !== 1'b1) begin n_fail++; $display("FAIL fo_af6: got %0b want 1", almost_full); end
      end
    end
    n_asserts++; if (full !== 1'b1 || count !== 4'd8 || pending !== 4'd0) begin n_fail++; $display("FAIL fo_full: got full=%0b count=%0d pending=%0d want 1 8 0", full, count, pending); end
    n_asserts++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fo_no_ovf: got %0b want 0", overflow); end
    drive_write(8'hFF, 1'b1);
    n_asserts++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fo_ovf: got %0b want 1", overflow); end
    n_asserts++; if (count !== 4'd8 || full !== 1'b1) begin n_fail++; $display("FAIL fo_hold: got count=%0d full=%0b want 8 1", count, full); end
    tick();
    n_asserts++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fo_ovf_pulse: got %0b want 0", overflow); end
    // Read and write together at full: read accepted, write rejected.
    r_enable = 1'b1;
    w_enable = 1'b1;
    w_data   = 8'hEE;
    w_commit = 1'b1;
    tick();
    idle();
    n_asserts++; if (count !== 4'd7 || overflow !== 1'b1) begin n_fail++; $display("FAIL fo_rw_full: got count=%0d ovf=%0b want 7 1", count, overflow); end
    for (int i = 1; i < DEPTH; i++) begin
      n_asserts++; if (r_data !== 8'h40 + 8'(i)) begin n_fail++; $display("FAIL fo_drain%0d: got %h want %h", i, r_data, 8'h40 + 8'(i)); end
      r_enable = 1'b1;
      tick();
      idle();
    end
    n_asserts++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fo_empty: got %0b want 1", empty); end
  endtask

  task automatic test_underflow();
    r_enable = 1'b1;
    tick();
    idle();
    n_asserts++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL uf_pulse: got %0b want 1", underflow); end
    n_asserts++; if (count !== 4'd0 || pending !== 4'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL uf_state: got count=%0d pending=%0d empty=%0b want 0 0 1", count, pending, empty); end
    tick();
    n_asserts++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL uf_single: got %0b want 0", underflow); end
    drive_write(8'h5A, 1'b1);
    n_asserts++; if (count !== 4'd1 || r_data !== 8'h5A) begin n_fail++; $display("FAIL uf_after: got count=%0d data=%h want 1 5a", count, r_data); end
    r_enable = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] pq[$];
    int errs = 0;
    for (int p = 0; p < 20; p++) begin
      for (int k = 0; k < 3; k++) begin
        w_enable = 1'b1;
        w_data   = 8'(p * 3 + k + 1);
        w_commit = (k == 2);
        r_enable = (q.size() > 0);
        if (q.size() > 0) begin
          n_asserts++; if (r_data !== q[0]) begin n_fail++; errs++; $display("FAIL b2b_data p%0d k%0d: got %h want %h", p, k, r_data, q[0]); end
          void'(q.pop_front());
        end
        pq.push_back(w_data);
        if (k == 2) begin
          while (pq.size() > 0) q.push_back(pq.pop_front());
        end
        tick();
        idle();
        n_asserts++; if (count !== CW'(q.size())) begin n_fail++; errs++; $display("FAIL b2b_count p%0d k%0d: got %0d want %0d", p, k, count, q.size()); end
      end
    end
    while (q.size() > 0) begin
      n_asserts++; if (r_data !== q[0]) begin n_fail++; $display("FAIL b2b_drain: got %h want %h", r_data, q[0]); end
      void'(q.pop_front());
      r_enable = 1'b1;
      tick();
      idle();
    end
    n_asserts++; if (empty !== 1'b1) begin n_fail++; $display("FAIL b2b_empty: got %0b want 1", empty); end
  endtask

  task automatic test_async_reset();
    drive_write(8'hC1, 1'b0);
    drive_write(8'hC2, 1'b1);
    drive_write(8'hD1, 1'b0);
    drive_write(8'hD2, 1'b0);
    drive_write(8'hD3, 1'b0);
    n_asserts++; if (count !== 4'd2 || pending !== 4'd3) begin n_fail++; $display("FAIL ar_pre: got count=%0d pending=%0d want 2 3", count, pending); end
    #2;
    n_rst = 1'b0;
    #1;
    n_asserts++; if (empty !== 1'b1 || count !== 4'd0 || pending !== 4'd0) begin n_fail++; $display("FAIL ar_immediate: got empty=%0b count=%0d pending=%0d want 1 0 0", empty, count, pending); end
    #2;
    n_rst = 1'b1;
    tick();
    n_asserts++; if (empty !== 1'b1 || full !== 1'b0 || count !== 4'd0) begin n_fail++; $display("FAIL ar_after: got empty=%0b full=%0b count=%0d want 1 0 0", empty, full, count); end
  endtask

  initial begin
    test_reset();
    test_commit_read();
    test_discard();
    test_full_overflow();
    test_underflow();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule : tb_pkt_fifo
